timebase_counter: RTL and testbench

Parametrised up/down/centre-aligned timebase counter with prescaler, one-shot mode and overflow/underflow event pulses. It is the second-generation counter of the peripheral timer datapath. It sits between the register file, which supplies period, prescale and mode, and the compare/PWM channels, which consume `count_val`, `dir` and the event pulses.

---
 rtl/timebase_pkg.sv | 23 ++
 rtl/timebase_prescaler.sv | 30 +++
 rtl/timebase_counter.sv | 144 ++++++++++++++
 tb/tb_timebase_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared constants and helpers for the timebase counter and its prescaler.
package timebase_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_UPDOWN = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Which event pulse closes a period (and ends a one-shot) in each mode.
  function automatic logic is_update_event(input logic [1:0] mode,
                                           input logic       top_is_zero,
                                           input logic       ovf,
                                           input logic       unf);
    case (mode)
      MODE_DOWN:   return unf;
      MODE_UPDOWN: return unf || (top_is_zero && ovf);
      default:     return ovf;
    endcase
  endfunction

endpackage

// File: rtl/timebase_prescaler.sv
// Prescaler: divides enabled cycles by prescale_a + 1 and flags the terminal count.
module timebase_prescaler #(
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PSC_WIDTH-1:0] prescale_a,
  output logic                 step
);

  logic [PSC_WIDTH-1:0] psc_cnt;
  logic                 terminal;

  // ">=" so a live shrink of prescale below psc_cnt ends the cycle instead of wrapping 2^N.
  assign terminal = (psc_cnt >= prescale_a);
  assign step     = en && terminal && !clr && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      psc_cnt <= '0;
    end else if (en) begin
      if (terminal) psc_cnt <= '0;
      else          psc_cnt <= psc_cnt + PSC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timebase_counter.sv
// Up/down/centre-aligned timebase counter with prescaler, one-shot and event pulses.
// Define TIMEBASE_PRELOAD_EN to buffer period/prescale in shadows loaded at update events.
module timebase_counter
  import timebase_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 count_reset,
  input  logic [1:0]           mode,
  input  logic                 one_shot,
  input  logic [WIDTH-1:0]     period,
  input  logic [PSC_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]     count_val,
  output logic                 dir,
  output logic                 tick,
  output logic                 ovf,
  output logic                 unf,
  output logic                 running
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0]     period_a;
  logic [PSC_WIDTH-1:0] prescale_a;
  logic [WIDTH-1:0]     top;
  logic                 step;
  logic [WIDTH-1:0]     nxt_count;
  logic                 nxt_dir;
  logic                 evt_ovf;
  logic                 evt_unf;
  logic                 update_evt;

  // period = 0 wraps to the all-ones top, giving the full 2^WIDTH range.
  assign top = period_a - ONE;

`ifdef TIMEBASE_PRELOAD_EN
  // Shadows reload only at period boundaries, so register writes land on the next period.
  always_ff @(posedge clk) begin
    if (rst || count_reset || !running || (step && update_evt)) begin
      period_a   <= period;
      prescale_a <= prescale;
    end
  end
`else
  assign period_a   = period;
  assign prescale_a = prescale;
`endif

  timebase_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .clr        (count_reset),
    .en         (en && running),
    .prescale_a (prescale_a),
    .step       (step)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    nxt_count = count_val;
    nxt_dir   = dir;
    evt_ovf   = 1'b0;
    evt_unf   = 1'b0;
    case (mode)
      MODE_DOWN: begin
        nxt_dir = DIR_DOWN;
        if (count_val == ZERO) begin
          nxt_count = top;
          evt_unf   = 1'b1;
        end else begin
          nxt_count = count_val - ONE;
        end
      end
      MODE_UPDOWN: begin
        if (top == ZERO) begin
          nxt_count = ZERO;
          nxt_dir   = DIR_UP;
          evt_ovf   = 1'b1;
        end else if (dir == DIR_UP) begin
          if (count_val > top) begin
            // Period lowered beneath the count: restart from zero rather than turn round.
            nxt_count = ZERO;
            evt_ovf   = 1'b1;
          end else if (count_val == top) begin
            nxt_count = top - ONE;
            nxt_dir   = DIR_DOWN;
            evt_ovf   = 1'b1;
          end else begin
            nxt_count = count_val + ONE;
          end
        end else begin
          if (count_val == ZERO) begin
            nxt_count = ONE;
            nxt_dir   = DIR_UP;
            evt_unf   = 1'b1;
          end else begin
            nxt_count = count_val - ONE;
          end
        end
      end
      default: begin
        nxt_dir = DIR_UP;
        if (count_val >= top) begin
          nxt_count = ZERO;
          evt_ovf   = 1'b1;
        end else begin
          nxt_count = count_val + ONE;
        end
      end
    endcase
  end

  assign update_evt = is_update_event(mode, (top == ZERO), evt_ovf, evt_unf);

  always_ff @(posedge clk) begin
    if (rst || count_reset) begin
      count_val <= ZERO;
      dir       <= DIR_UP;
      tick      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      running   <= 1'b1;
    end else if (step) begin
      count_val <= nxt_count;
      dir       <= nxt_dir;
      tick      <= 1'b1;
      ovf       <= evt_ovf;
      unf       <= evt_unf;
      if (one_shot && update_evt) running <= 1'b0;
    end else begin
      tick <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timebase_counter.sv
// Directed bench for timebase_counter: per-cycle expectations queued, then popped against outputs.
module tb_timebase_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        count_reset;
  logic [1:0]  mode;
  logic        one_shot;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic [15:0] count_val;
  logic        dir;
  logic        tick;
  logic        ovf;
  logic        unf;
  logic        running;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] count;
    logic        dir;
    logic        tick;
    logic        ovf;
    logic        unf;
    logic        running;
  } exp_t;

  exp_t sb[$];

  timebase_counter #(.WIDTH(16), .PSC_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .count_reset (count_reset),
    .mode        (mode),
    .one_shot    (one_shot),
    .period      (period),
    .prescale    (prescale),
    .count_val   (count_val),
    .dir         (dir),
    .tick        (tick),
    .ovf         (ovf),
    .unf         (unf),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One queued entry describes the outputs after the next rising edge.
  task automatic expect_cycle(input string tag, input int cnt, input logic d, input logic t,
                              input logic o, input logic u, input logic r);
    exp_t e;
    e.tag = tag; e.count = 16'(cnt); e.dir = d; e.tick = t;
    e.ovf = o; e.unf = u; e.running = r;
    sb.push_back(e);
  endtask

  task automatic drain_all();
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".count"},   32'(count_val), 32'(e.count));
      check({e.tag, ".dir"},     32'(dir),       32'(e.dir));
      check({e.tag, ".tick"},    32'(tick),      32'(e.tick));
      check({e.tag, ".ovf"},     32'(ovf),       32'(e.ovf));
      check({e.tag, ".unf"},     32'(unf),       32'(e.unf));
      check({e.tag, ".running"}, 32'(running),   32'(e.running));
    end
  endtask

  task automatic soft_clear();
    count_reset = 1'b1;
    expect_cycle("clr", 0, 0, 0, 0, 0, 1);
    drain_all();
    count_reset = 1'b0;
  endtask

  initial begin
    int pc;
    logic pd;
    int dn_seq[5];
    int ud_cnt[8];
    logic ud_dir[8];

    rst = 1'b1; en = 1'b1; count_reset = 1'b0; mode = 2'b00;
    one_shot = 1'b0; period = 16'd5; prescale = 8'd0;
    expect_cycle("reset", 0, 0, 0, 0, 0, 1);
    expect_cycle("reset", 0, 0, 0, 0, 0, 1);
    drain_all();
    rst = 1'b0;

    // Up mode, period 5, step every cycle
    for (int i = 1; i <= 4; i++) expect_cycle("up", i, 0, 1, 0, 0, 1);
    expect_cycle("up_wrap", 0, 0, 1, 1, 0, 1);
    expect_cycle("up", 1, 0, 1, 0, 0, 1);
    drain_all();

    // Down mode, period 4, prescale 2: first step from 0 reloads top
    mode = 2'b01; period = 16'd4; prescale = 8'd2;
    soft_clear();
    dn_seq = '{3, 2, 1, 0, 3};
    pc = 0; pd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_cycle("dn_hold", pc, pd, 0, 0, 0, 1);
      expect_cycle("dn_hold", pc, pd, 0, 0, 0, 1);
      expect_cycle("dn", dn_seq[k], 1, 1, 0, (k == 0 || k == 4), 1);
      pc = dn_seq[k]; pd = 1'b1;
    end
    drain_all();

    // Centre-aligned, period 4
    mode = 2'b10; period = 16'd4; prescale = 8'd0;
    soft_clear();
    ud_cnt = '{1, 2, 3, 2, 1, 0, 1, 2};
    ud_dir = '{0, 0, 0, 1, 1, 1, 0, 0};
    for (int k = 0; k < 8; k++)
      expect_cycle("updn", ud_cnt[k], ud_dir[k], 1, (k == 3), (k == 6), 1);
    drain_all();

    // One-shot up, period 3
    mode = 2'b00; period = 16'd3; one_shot = 1'b1;
    soft_clear();
    expect_cycle("os", 1, 0, 1, 0, 0, 1);
    expect_cycle("os", 2, 0, 1, 0, 0, 1);
    expect_cycle("os_end", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) expect_cycle("os_frozen", 0, 0, 0, 0, 0, 0);
    drain_all();
    soft_clear();
    expect_cycle("os_rearm", 1, 0, 1, 0, 0, 1);
    expect_cycle("os_rearm", 2, 0, 1, 0, 0, 1);
    drain_all();
    one_shot = 1'b0;

    // Period lowered 10 -> 4 while count is 6
    period = 16'd10;
    soft_clear();
    for (int i = 1; i <= 6; i++) expect_cycle("per10", i, 0, 1, 0, 0, 1);
    drain_all();
    period = 16'd4;
`ifdef TIMEBASE_PRELOAD_EN
    for (int i = 7; i <= 9; i++) expect_cycle("per_old", i, 0, 1, 0, 0, 1);
    expect_cycle("per_wrap", 0, 0, 1, 1, 0, 1);
`else
    expect_cycle("per_wrap", 0, 0, 1, 1, 0, 1);
`endif
    for (int i = 1; i <= 3; i++) expect_cycle("per4", i, 0, 1, 0, 0, 1);
    expect_cycle("per4_wrap", 0, 0, 1, 1, 0, 1);
    drain_all();

    // Enable dropped with psc_cnt = 2 of prescale 3
    period = 16'd0; prescale = 8'd3;
    soft_clear();
    expect_cycle("en_pre", 0, 0, 0, 0, 0, 1);
    expect_cycle("en_pre", 0, 0, 0, 0, 0, 1);
    drain_all();
    en = 1'b0;
    for (int i = 0; i < 5; i++) expect_cycle("en_off", 0, 0, 0, 0, 0, 1);
    drain_all();
    en = 1'b1;
    expect_cycle("en_resume", 0, 0, 0, 0, 0, 1);
    expect_cycle("en_step", 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) expect_cycle("psc_hold", 1, 0, 0, 0, 0, 1);
    expect_cycle("psc_step", 2, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) expect_cycle("psc_hold", 2, 0, 0, 0, 0, 1);
    drain_all();
    rst = 1'b1;
    expect_cycle("mid_rst", 0, 0, 0, 0, 0, 1);
    drain_all();
    rst = 1'b0;

    // Full-range down: period 0 makes top 16'hFFFF
    mode = 2'b01; period = 16'd0; prescale = 8'd0;
    soft_clear();
    expect_cycle("full_dn", 16'hFFFF, 1, 1, 0, 1, 1);
    expect_cycle("full_dn", 16'hFFFE, 1, 1, 0, 0, 1);
    expect_cycle("full_dn", 16'hFFFD, 1, 1, 0, 0, 1);
    drain_all();

    // Centre-aligned with top 0: holds 0, overflow on every step
    mode = 2'b10; period = 16'd1;
    soft_clear();
    for (int i = 0; i < 3; i++) expect_cycle("ud_top0", 0, 0, 1, 1, 0, 1);
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
